// File: rtl/sqrlog_pkg.sv
// Shared types and constants for the square/add/log power datapath.
// SQRLOG_LATENCY is the stage total of the square, add and log pipeline.
package sqrlog_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_DROP
    } frame_st_t;

    localparam int SQRLOG_LEN     = 8192;
    localparam int SQRLOG_LATENCY = 42;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
        return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register that carries the stream qualifiers alongside
// the arithmetic pipeline.
module pipe_delay
    import sqrlog_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = SQRLOG_LATENCY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/sqrlog_frame_ctrl.sv
// Frame-write scheduler: admits or drops whole frames at the delayed sop
// depending on FIFO room, and strobes writes aligned to the pipeline result.
module sqrlog_frame_ctrl
    import sqrlog_pkg::*;
#(
    parameter int LEN        = SQRLOG_LEN,
    parameter int LATENCY    = SQRLOG_LATENCY,
    parameter int FIFO_DEPTH = 16384,
    parameter int USEDW_W    = 15
) (
    input  logic               fft_clk,
    input  logic               reset_n,
    input  logic               fft_valid,
    input  logic               fft_sop,
    input  logic               fft_eop,
    input  logic [USEDW_W-1:0] fifo_wrusedw,
    input  logic               fifo_full,
    input  logic               err_clr,
    output logic               fft_ready,
    output logic               wrreq,
    output logic               frame_active,
    output logic [15:0]        drop_cnt,
    output logic               err_framing,
    output logic               err_overflow
);

    localparam int CNT_W = $clog2(LEN + 1);
    localparam logic [USEDW_W:0] DEPTH_W = (USEDW_W + 1)'(FIFO_DEPTH);
    localparam logic [USEDW_W:0] LEN_W   = (USEDW_W + 1)'(LEN);

    logic [2:0] dly_in, dly_out;
    logic       d_valid, d_sop, d_eop;

    assign dly_in = {fft_valid & fft_eop, fft_valid & fft_sop, fft_valid};

    pipe_delay #(
        .WIDTH(3),
        .DEPTH(LATENCY)
    ) u_qual_dly (
        .clk  (fft_clk),
        .rst_n(reset_n),
        .din  (dly_in),
        .dout (dly_out)
    );

    assign d_valid = dly_out[0];
    assign d_sop   = dly_out[1];
    assign d_eop   = dly_out[2];

    // Extra headroom bit keeps the free-space subtraction from wrapping.
    logic [USEDW_W:0] used_w, space_w;
    logic             space_ok, admit_now;

    assign used_w    = {1'b0, fifo_wrusedw};
    assign space_w   = DEPTH_W - used_w;
    assign space_ok  = (used_w <= DEPTH_W) && (space_w >= LEN_W);
    assign admit_now = d_sop & space_ok;

    frame_st_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic              err_framing_q, err_framing_d;
    logic              err_overflow_q, err_overflow_d;
    logic              frame_active_q, frame_active_d;
    logic              framing_set, drop_inc;

    assign fft_ready = !fifo_full;
    assign wrreq     = d_valid & ((state_q == ST_ACCEPT) | admit_now);
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        framing_set = 1'b0;
        drop_inc    = 1'b0;
        if (d_sop) begin
            if (state_q == ST_ACCEPT) framing_set = 1'b1;
            if (space_ok) begin
                cnt_d = CNT_W'(1);
                if (d_eop) begin
                    state_d = ST_IDLE;
                    if (LEN != 1) framing_set = 1'b1;
                end else if (LEN == 1) begin
                    state_d     = ST_IDLE;
                    framing_set = 1'b1;
                end else begin
                    state_d = ST_ACCEPT;
                end
            end else begin
                drop_inc = 1'b1;
                state_d  = d_eop ? ST_IDLE : ST_DROP;
            end
        end else if (d_valid) begin
            case (state_q)
                ST_ACCEPT: begin
                    cnt_d = cnt_inc;
                    if (d_eop) begin
                        state_d = ST_IDLE;
                        if (cnt_inc != CNT_W'(LEN)) framing_set = 1'b1;
                    end else if (cnt_inc == CNT_W'(LEN)) begin
                        state_d     = ST_IDLE;
                        framing_set = 1'b1;
                    end
                end
                ST_DROP: begin
                    if (d_eop) state_d = ST_IDLE;
                end
                default: begin
                    if (d_eop) framing_set = 1'b1;
                end
            endcase
        end
        drop_cnt_d     = sat_inc16(drop_cnt_q, drop_inc);
        err_framing_d  = (err_framing_q & ~err_clr) | framing_set;
        err_overflow_d = (err_overflow_q & ~err_clr) | (wrreq & fifo_full);
        frame_active_d = (state_d == ST_ACCEPT);
    end

    always_ff @(posedge fft_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            drop_cnt_q     <= '0;
            err_framing_q  <= 1'b0;
            err_overflow_q <= 1'b0;
            frame_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            drop_cnt_q     <= drop_cnt_d;
            err_framing_q  <= err_framing_d;
            err_overflow_q <= err_overflow_d;
            frame_active_q <= frame_active_d;
        end
    end

    assign frame_active = frame_active_q;
    assign drop_cnt     = drop_cnt_q;
    assign err_framing  = err_framing_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_sqrlog_frame_ctrl.sv
// Directed bench for sqrlog_frame_ctrl with a frame-level reference model
// compared every cycle, plus literal per-scenario expectations.
module tb_sqrlog_frame_ctrl;

    localparam int LEN = 8;
    localparam int LAT = 4;
    localparam int FD  = 16;
    localparam int UW  = 5;

    logic          fft_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          fft_valid = 1'b0, fft_sop = 1'b0, fft_eop = 1'b0;
    logic [UW-1:0] fifo_wrusedw = '0;
    logic          fifo_full = 1'b0;
    logic          err_clr = 1'b0;
    logic          fft_ready, wrreq, frame_active, err_framing, err_overflow;
    logic [15:0]   drop_cnt;

    sqrlog_frame_ctrl #(
        .LEN(LEN), .LATENCY(LAT), .FIFO_DEPTH(FD), .USEDW_W(UW)
    ) dut (
        .fft_clk(fft_clk), .reset_n(reset_n),
        .fft_valid(fft_valid), .fft_sop(fft_sop), .fft_eop(fft_eop),
        .fifo_wrusedw(fifo_wrusedw), .fifo_full(fifo_full), .err_clr(err_clr),
        .fft_ready(fft_ready), .wrreq(wrreq), .frame_active(frame_active),
        .drop_cnt(drop_cnt), .err_framing(err_framing), .err_overflow(err_overflow)
    );

    always #5 fft_clk = ~fft_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_seen = 0;
    int first_wr = -1;

    // Reference model: delayed beats as a queue, frame progress as a write count.
    bit [2:0] dl[$];
    bit       m_writing, m_dropping, m_errf, m_erro;
    int       m_wcount, m_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        dl.delete();
        for (int i = 0; i < LAT; i++) dl.push_back(3'b000);
        m_writing = 0; m_dropping = 0; m_errf = 0; m_erro = 0;
        m_wcount = 0; m_drop = 0;
    endtask

    function automatic bit room_ok();
        int u = int'(fifo_wrusedw);
        return (u <= FD) && (FD - u >= LEN);
    endfunction

    function automatic bit exp_wr();
        bit dv = dl[0][0];
        bit ds = dl[0][1];
        return dv && (ds ? room_ok() : m_writing);
    endfunction

    task automatic compare_now();
        chk("wrreq", wrreq, exp_wr());
        chk("frame_active", frame_active, m_writing);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("err_framing", err_framing, m_errf);
        chk("err_overflow", err_overflow, m_erro);
        chk("fft_ready", fft_ready, !fifo_full);
    endtask

    task automatic model_step();
        bit dv = dl[0][0], ds = dl[0][1], de = dl[0][2];
        bit set_f = 0;
        bit set_o = exp_wr() && fifo_full;
        if (ds) begin
            if (m_writing) set_f = 1;
            if (room_ok()) begin
                m_wcount   = 1;
                m_dropping = 0;
                m_writing  = !de && (LEN > 1);
                if (de != (LEN == 1)) set_f = 1;
            end else begin
                if (m_drop < 65535) m_drop++;
                m_writing  = 0;
                m_dropping = !de;
            end
        end else if (dv && m_writing) begin
            m_wcount++;
            if (de || m_wcount == LEN) begin
                m_writing = 0;
                if (m_wcount != LEN || !de) set_f = 1;
            end
        end else if (de) begin
            if (m_dropping) m_dropping = 0;
            else set_f = 1;
        end
        m_errf = (m_errf && !err_clr) || set_f;
        m_erro = (m_erro && !err_clr) || set_o;
        void'(dl.pop_front());
        dl.push_back({fft_valid & fft_eop, fft_valid & fft_sop, fft_valid});
    endtask

    // Called at a negedge: drive inputs, check, advance the model past the next posedge.
    task automatic tick(input bit v, input bit s, input bit e);
        fft_valid = v; fft_sop = s; fft_eop = e;
        #1;
        compare_now();
        if (wrreq === 1'b1) begin
            wr_seen++;
            if (first_wr < 0) first_wr = cyc;
        end
        if (reset_n) model_step();
        cyc++;
        @(negedge fft_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0);
    endtask

    task automatic send_frame(input int n, input int eop_at, input int sop2_at,
                              input int gap_at, input int gap_len, output int start);
        wr_seen  = 0;
        first_wr = -1;
        start    = cyc;
        for (int i = 1; i <= n; i++) begin
            if (i == gap_at) idle(gap_len);
            tick(1, (i == 1) || (i == sop2_at), i == eop_at);
        end
        idle(LAT + 2);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(0, 0, 0);
        err_clr = 1'b0;
        tick(0, 0, 0);
    endtask

    int st;

    initial begin
        model_reset();
        @(negedge fft_clk);
        idle(2);
        chk("reset_wrreq", wrreq, 0);
        chk("reset_drop_cnt", drop_cnt, 0);
        chk("reset_frame_active", frame_active, 0);
        fifo_full = 1'b1;
        #1;
        chk("ready_in_reset", fft_ready, 0);
        fifo_full = 1'b0;
        reset_n = 1'b1;
        idle(2);

        // clean frame into empty FIFO
        send_frame(8, 8, 0, 0, 0, st);
        chk("clean_writes", wr_seen, 8);
        chk("clean_latency", first_wr - st, 4);
        chk("clean_err", err_framing, 0);

        // one word short of room: whole frame dropped
        fifo_wrusedw = 5'(FD - LEN + 1);
        send_frame(8, 8, 0, 0, 0, st);
        chk("drop_writes", wr_seen, 0);
        chk("drop_cnt_1", drop_cnt, 1);
        fifo_wrusedw = '0;
        send_frame(8, 8, 0, 0, 0, st);
        chk("after_drop_writes", wr_seen, 8);

        // exactly LEN words free: admitted
        fifo_wrusedw = 5'(FD - LEN);
        send_frame(8, 8, 0, 0, 0, st);
        chk("exact_room_writes", wr_seen, 8);
        chk("exact_room_drop", drop_cnt, 1);
        fifo_wrusedw = '0;

        // three-cycle valid gap mid-frame
        send_frame(8, 8, 0, 4, 3, st);
        chk("gap_writes", wr_seen, 8);
        chk("gap_err", err_framing, 0);

        // early eop
        send_frame(5, 5, 0, 0, 0, st);
        chk("early_eop_writes", wr_seen, 5);
        chk("early_eop_err", err_framing, 1);
        pulse_clr();
        chk("err_cleared", err_framing, 0);

        // missing eop followed by two extra valids
        send_frame(10, 0, 0, 0, 0, st);
        chk("no_eop_writes", wr_seen, 8);
        chk("no_eop_err", err_framing, 1);
        pulse_clr();

        // second sop at sample 3 restarts the count
        send_frame(10, 10, 3, 0, 0, st);
        chk("dbl_sop_writes", wr_seen, 10);
        chk("dbl_sop_err", err_framing, 1);
        pulse_clr();
        send_frame(8, 8, 0, 0, 0, st);
        chk("post_restart_err", err_framing, 0);

        // writes into a full FIFO
        fifo_full = 1'b1;
        send_frame(8, 8, 0, 0, 0, st);
        chk("ovf_writes", wr_seen, 8);
        chk("ovf_flag", err_overflow, 1);
        fifo_full = 1'b0;
        pulse_clr();
        chk("ovf_cleared", err_overflow, 0);

        // reset while writes are in flight
        wr_seen = 0;
        for (int i = 1; i <= 5; i++) tick(1, i == 1, 0);
        chk("pre_reset_writing", wr_seen, 1);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_wrreq", wrreq, 0);
        chk("midrst_drop_cnt", drop_cnt, 0);
        idle(2);
        reset_n = 1'b1;
        wr_seen = 0;
        for (int i = 6; i <= 8; i++) tick(1, 0, i == 8);
        idle(LAT + 2);
        chk("post_reset_writes", wr_seen, 0);
        chk("orphan_eop_err", err_framing, 1);
        pulse_clr();
        send_frame(8, 8, 0, 0, 0, st);
        chk("fresh_frame_writes", wr_seen, 8);
        chk("fresh_frame_err", err_framing, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
